regfile_sb: RTL

- Parametrised successor to the datapath's 2-read/1-write register heap.
- Register array of configurable width and depth with:
  - asynchronous active-low clear of all registers;
  - optional hardwired zero register;
  - write-to-read bypass;
  - per-register pending-write scoreboard (busy bits).
- Sits between decode (reads, reservations) and writeback (writes); the pipeline uses the busy outputs for load-use and multi-cycle stall detection.

---
 rtl/regfile_sb_pkg.sv | 12 +
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb_scoreboard.sv | 59 +++++
 rtl/regfile_sb.sv | 78 +++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  function automatic logic is_zero_reg(input int unsigned addr, input bit zero_reg);
    return zero_reg && (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: write port, two read ports, reservation and busy status.
interface regfile_sb_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              we;
  logic [ADDR_W-1:0] wreg;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] rreg1;
  logic [ADDR_W-1:0] rreg2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_reg;
  logic              flush;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output we, wreg, wdata, rreg1, rreg2, rsv_en, rsv_reg, flush,
    input  rdata1, rdata2, busy1, busy2, busy_cnt
  );

  modport slave (
    input  we, wreg, wdata, rreg1, rreg2, rsv_en, rsv_reg, flush,
    output rdata1, rdata2, busy1, busy2, busy_cnt
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: per-register pending-write flags and a registered popcount.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_en_i,
  input  logic [ADDR_W-1:0]    clr_reg_i,
  input  logic                 flush_i,
  input  logic                 rsv_en_i,
  input  logic [ADDR_W-1:0]    rsv_reg_i,
  output logic [2**ADDR_W-1:0] busy_o,
  output logic [ADDR_W:0]      busy_cnt_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsv_ok;
  logic             inc;
  logic             dec;

  assign rsv_ok = rsv_en_i && !is_zero_reg(32'(rsv_reg_i), ZERO_REG);

  // Later assignments win: write-clear < flush < reservation.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_reg_i] = 1'b0;
    if (flush_i)  busy_d = '0;
    if (rsv_ok)   busy_d[rsv_reg_i] = 1'b1;
  end

  // Count only real transitions so re-reserving or clearing an idle register is a no-op.
  always_comb begin
    inc = rsv_ok && !busy_q[rsv_reg_i];
    dec = clr_en_i && busy_q[clr_reg_i] && !(rsv_ok && (rsv_reg_i == clr_reg_i));
    if (flush_i) cnt_d = CW'(rsv_ok);
    else         cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with optional zero register, write bypass and busy scoreboard.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic [ADDR_W:0]   busy_cnt;
  logic              wr_en;
  logic              hit1, hit2;
  logic              zero1, zero2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              bz1, bz2;

  assign wr_en = bus.we && !is_zero_reg(32'(bus.wreg), ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wreg] <= bus.wdata;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_en_i   (wr_en),
    .clr_reg_i  (bus.wreg),
    .flush_i    (bus.flush),
    .rsv_en_i   (bus.rsv_en),
    .rsv_reg_i  (bus.rsv_reg),
    .busy_o     (busy_vec),
    .busy_cnt_o (busy_cnt)
  );

  assign hit1  = BYPASS && wr_en && (bus.wreg == bus.rreg1);
  assign hit2  = BYPASS && wr_en && (bus.wreg == bus.rreg2);
  assign zero1 = is_zero_reg(32'(bus.rreg1), ZERO_REG);
  assign zero2 = is_zero_reg(32'(bus.rreg2), ZERO_REG);

  // Outputs are gated by rst_n so a bypassed write cannot leak through while reset is held.
  always_comb begin
    rd1 = regs_q[bus.rreg1];
    if (!rst_n || zero1) rd1 = '0;
    else if (hit1)       rd1 = bus.wdata;
  end

  always_comb begin
    rd2 = regs_q[bus.rreg2];
    if (!rst_n || zero2) rd2 = '0;
    else if (hit2)       rd2 = bus.wdata;
  end

  assign bz1 = rst_n && !zero1 && !hit1 && busy_vec[bus.rreg1];
  assign bz2 = rst_n && !zero2 && !hit2 && busy_vec[bus.rreg2];

  assign bus.rdata1   = rd1;
  assign bus.rdata2   = rd2;
  assign bus.busy1    = bz1;
  assign bus.busy2    = bz2;
  assign bus.busy_cnt = busy_cnt;

endmodule
